// File: rtl/piso_tx_arbiter_if.sv
// Requester-side and PISO-side handshake bundle for piso_tx_arbiter.
// The arbiter connects through the slave modport; producers and the PISO side use master.
interface piso_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [DATA_W-1:0]         data_o;
    logic                      valid_o;
    logic                      ready_i;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  ready_i,
        output req_ready_o,
        output data_o,
        output valid_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output ready_i,
        input  req_ready_o,
        input  data_o,
        input  valid_o
    );
endinterface

// File: rtl/piso_tx_arbiter.sv
// Round-robin burst arbiter sharing one PISO parallel port between NUM_REQ byte sources.
// Optional per-requester transfer counters (xfer_cnt_o) are enabled by PISO_ARB_STATS_EN.
module piso_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                pclk_i,
    input  logic                rst_i,
    piso_tx_arbiter_if.slave    bus,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic                busy_o
`ifdef PISO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] xfer_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] grant_d;

    logic [PTR_W-1:0]   winner;
    logic               win_found;
    logic [DATA_W-1:0]  gnt_data;
    logic               gnt_valid;
    logic               xfer;

    logic [DATA_W-1:0]  data_int;
    logic               valid_int;
    logic [NUM_REQ-1:0] req_ready_int;
    logic               busy_int;

    // Rotating priority: search starts one past the last winner and wraps modulo NUM_REQ.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        winner    = last_ptr_q;
        win_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(last_ptr_q) + i) % NUM_REQ;
            cand = PTR_W'(idx);
            if (!win_found && bus.req_valid_i[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // last_ptr doubles as the granted index while in GRANT.
    assign gnt_data  = bus.req_data_i[last_ptr_q*DATA_W +: DATA_W];
    assign gnt_valid = bus.req_valid_i[last_ptr_q];
    assign xfer      = (state_q == GRANT) && gnt_valid && bus.ready_i;

    always_comb begin
        state_d       = state_q;
        last_ptr_d    = last_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        grant_d       = grant_o;
        data_int      = '0;
        valid_int     = 1'b0;
        req_ready_int = '0;
        busy_int      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    last_ptr_d  = winner;
                    grant_d     = NUM_REQ'(1) << winner;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                busy_int                  = 1'b1;
                data_int                  = gnt_data;
                valid_int                 = gnt_valid;
                req_ready_int[last_ptr_q] = bus.ready_i;
                if (!gnt_valid) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                end else if (xfer) begin
                    if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_o     <= '0;
            burst_cnt_q <= '0;
            last_ptr_q  <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            grant_o     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign bus.data_o      = data_int;
    assign bus.valid_o     = valid_int;
    assign bus.req_ready_o = req_ready_int;
    assign busy_o          = busy_int;

`ifdef PISO_ARB_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        logic [15:0] cnt_q;
        always_ff @(posedge pclk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (xfer && (last_ptr_q == PTR_W'(k)) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign xfer_cnt_o[k*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
- Round-robin arbiter that shares one PISO parallel input port between NUM_REQ byte sources.
- Each requester presents a byte with a valid/ready handshake.
- The arbiter grants one requester at a time for a burst of up to MAX_BURST bytes and forwards that requester's bytes to the PISO's data_i/valid_i/ready_o interface.
- Sits between the transmit byte producers and the PISO, in the PISO parallel clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the PISO data_i width.
- MAX_BURST, 4, maximum bytes accepted per grant before rotation (>=1).

Ports:
- pclk_i  input  1  parallel clock; all logic on posedge.
- rst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_data_i  input  NUM_REQ*DATA_W  packed bytes; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  output  NUM_REQ  per-requester accept.
- grant_o  output  NUM_REQ  one-hot registered grant.
- data_o  output  DATA_W  byte to the PISO data_i.
- valid_o  output  1  to the PISO valid_i.
- ready_i  input  1  from the PISO ready_o.
- busy_o  output  1  high while in GRANT.

Behaviour:
- Reset values (on a rst_i=1 edge):
  - state=IDLE, grant_o=0, burst_cnt=0.
  - last_ptr=NUM_REQ-1, so requester 0 wins first.
  - req_ready_o=0, valid_o=0, data_o=0, busy_o=0.
- Transfer definition: valid_o && ready_i at a pclk_i edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - No grant is held; valid_o=0 and req_ready_o=0.
  - If any req_valid_i is set, pick the first set bit searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - Next edge: grant_o=onehot(winner), last_ptr=winner, burst_cnt=0, state=GRANT.
  - Grant latency is 1 cycle from the first request seen in IDLE.
- GRANT, for granted index g:
  - Outputs (combinational): data_o=req_data_i[g], valid_o=req_valid_i[g], req_ready_o[g]=ready_i, all other req_ready_o bits=0.
  - On each transfer, burst_cnt increments.
  - Exit to IDLE at the next edge, clearing grant_o and burst_cnt, when either:
    - a transfer occurs with burst_cnt==MAX_BURST-1, or
    - req_valid_i[g]==0 (requester idle; no transfer that cycle).
  - Otherwise remain in GRANT.
- Every rotation costs exactly 1 IDLE cycle, so no byte is presented in that cycle.
- Fairness: a continuously requesting source waits at most (NUM_REQ-1)*(MAX_BURST+1) transfer-or-idle slots.
- Back-pressure: ready_i=0 holds the grant indefinitely; burst_cnt counts only transfers.
- Non-granted requester toggling valid has no effect on outputs.
- Idle condition: when all req_valid_i are 0, the FSM stays in IDLE and last_ptr is unchanged.
- Reset mid-burst: rst_i=1 overrides all; the in-flight byte is not transferred and pointer state returns to reset values.
- Width rules:
  - burst_cnt width is $clog2(MAX_BURST)+1.
  - last_ptr width is $clog2(NUM_REQ), and it wraps modulo NUM_REQ.
- data_o is driven 0 when not in GRANT.

Optional Feature:
- Macro: PISO_ARB_STATS_EN.
- Defined:
  - Adds output xfer_cnt_o, 16 bits per requester, packed as NUM_REQ*16.
  - Each counter increments on a transfer from that requester and saturates at 16'hFFFF.
  - Reset to 0 by rst_i.
- Undefined:
  - Port and counters are absent.
  - Arbitration behaviour is identical.

Test Plan:
- Reset then a single request:
  - Stimulus: hold rst_i 2 cycles, then req_valid_i=4'b0100 with data 8'hA5, ready_i=1.
  - Response: grant_o=4'b0100 one edge later; data_o=8'hA5, valid_o=1.
  - After 4 transfers: IDLE for 1 cycle, then grant 4'b0100 again.
- All requesters saturated:
  - Stimulus: req_valid_i=4'b1111, ready_i=1.
  - Response: grant order 0,1,2,3,0, each holding exactly 4 transfers, with 1 idle cycle between grants.
- Early release:
  - Stimulus: requester 1 drops valid after 2 transfers.
  - Response: FSM returns to IDLE; requester 2 is granted next; requester 1 receives exactly 2 req_ready_o pulses.
- PISO back-pressure:
  - Stimulus: in GRANT to requester 3, ready_i=0 for 10 cycles.
  - Response: grant_o stays 4'b1000; req_ready_o=0; burst_cnt unchanged; data_o stable.
- Reset mid-burst:
  - Stimulus: rst_i=1 during the second transfer of requester 2.
  - Response: next edge has grant_o=0, valid_o=0; the following grant goes to requester 0.
- With PISO_ARB_STATS_EN, 10 bytes from requester 0 and 3 bytes from requester 1: xfer_cnt_o fields read 10 and 3, others 0.
